// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two-requester front end for a single shared combinational ALU. Each
// requester has a valid/ready request channel and a valid/ready response
// channel. A round-robin arbiter moves at most one request per cycle into a
// single issue register. The issue register drives the external ALU. One
// edge later the ALU result is written into the response buffer of the
// requester that owns the operation.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reqN_valid / reqN_ready request handshake, N = 0,1
//   reqN_a, reqN_b          32-bit operands
//   reqN_cmd, reqN_s        opcode (7 = illegal), signed-mode flag
//   rspN_valid / rspN_ready response handshake
//   rspN_data               32-bit result
//   rspN_eg, rspN_ne        compare flags from the ALU
//   rspN_err                illegal-opcode flag
//   alu_a, alu_b            operands presented to the shared ALU
//   alu_cmd, alu_s          opcode and signed flag presented to the ALU
//   alu_out, alu_eg, alu_ne combinational results returned by the ALU
//   op_count                wrapping count of response-buffer writes
//
// Timing
//   edge T   : granted request captured into the issue register
//   edge T+1 : ALU result written into the tagged response buffer, so
//              rspN_valid rises here. The issue register empties unless a
//              new grant refills it on the same edge.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_cmd,
    input  logic        req0_s,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_cmd,
    input  logic        req1_s,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,
    output logic        rsp0_eg,
    output logic        rsp0_ne,
    output logic        rsp0_err,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,
    output logic        rsp1_eg,
    output logic        rsp1_ne,
    output logic        rsp1_err,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_cmd,
    output logic        alu_s,
    input  logic [31:0] alu_out,
    input  logic        alu_eg,
    input  logic        alu_ne,

    output logic [15:0] op_count
);

    localparam logic [2:0] CMD_ILLEGAL = 3'd7;
    localparam logic       PRIO_RESET  = (RR_INIT != 0);

    // Issue register
    logic        iss_valid_q, iss_valid_d;
    logic        iss_tag_q,   iss_tag_d;
    logic [31:0] iss_a_q,     iss_a_d;
    logic [31:0] iss_b_q,     iss_b_d;
    logic [2:0]  iss_cmd_q,   iss_cmd_d;
    logic        iss_s_q,     iss_s_d;

    // Response buffers
    logic        rsp0_valid_q, rsp0_valid_d;
    logic [31:0] rsp0_data_q,  rsp0_data_d;
    logic        rsp0_eg_q,    rsp0_eg_d;
    logic        rsp0_ne_q,    rsp0_ne_d;
    logic        rsp0_err_q,   rsp0_err_d;

    logic        rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp1_data_q,  rsp1_data_d;
    logic        rsp1_eg_q,    rsp1_eg_d;
    logic        rsp1_ne_q,    rsp1_ne_d;
    logic        rsp1_err_q,   rsp1_err_d;

    // Round-robin priority: 0 = requester 0 wins a tie, 1 = requester 1
    logic        prio_q, prio_d;

    logic [15:0] op_count_q, op_count_d;

    // Arbitration signals
    logic rsp0_drain, rsp1_drain;
    logic elig0, elig1;
    logic cand0, cand1;
    logic grant0, grant1;

    // Writeback signals
    logic        wb_illegal;
    logic        wb0, wb1;
    logic [31:0] wb_data;
    logic        wb_eg, wb_ne, wb_err;

    // -------------------------------------------------------------------------
    // Eligibility and arbitration
    // -------------------------------------------------------------------------
    // A requester may issue only if its response buffer will have room at
    // writeback time (empty now, or draining on this edge) and it has no
    // operation already sitting in the issue register. This caps each
    // requester at one outstanding operation. rst_n gates the candidates so
    // ready stays low for the whole time reset is asserted.
    always_comb begin
        rsp0_drain = rsp0_valid_q & rsp0_ready;
        rsp1_drain = rsp1_valid_q & rsp1_ready;

        elig0 = (~rsp0_valid_q | rsp0_drain) & ~(iss_valid_q & ~iss_tag_q);
        elig1 = (~rsp1_valid_q | rsp1_drain) & ~(iss_valid_q &  iss_tag_q);

        cand0 = req0_valid & elig0 & rst_n;
        cand1 = req1_valid & elig1 & rst_n;

        grant0 = cand0 & (~cand1 | ~prio_q);
        grant1 = cand1 & (~cand0 |  prio_q);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Priority passes to the other requester after any grant. It holds on an
    // idle cycle.
    always_comb begin
        prio_d = prio_q;
        if (grant0) begin
            prio_d = 1'b1;
        end else if (grant1) begin
            prio_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Issue register next state
    // -------------------------------------------------------------------------
    // The operands are copied at acceptance. Later changes on reqN_* cannot
    // reach the result. When nothing is granted, only the valid bit drops.
    // The ALU outputs are gated by that bit.
    always_comb begin
        iss_valid_d = grant0 | grant1;
        iss_tag_d   = iss_tag_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_cmd_d   = iss_cmd_q;
        iss_s_d     = iss_s_q;
        if (grant0) begin
            iss_tag_d = 1'b0;
            iss_a_d   = req0_a;
            iss_b_d   = req0_b;
            iss_cmd_d = req0_cmd;
            iss_s_d   = req0_s;
        end else if (grant1) begin
            iss_tag_d = 1'b1;
            iss_a_d   = req1_a;
            iss_b_d   = req1_b;
            iss_cmd_d = req1_cmd;
            iss_s_d   = req1_s;
        end
    end

    assign alu_a   = iss_valid_q ? iss_a_q   : 32'd0;
    assign alu_b   = iss_valid_q ? iss_b_q   : 32'd0;
    assign alu_cmd = iss_valid_q ? iss_cmd_q : 3'd0;
    assign alu_s   = iss_valid_q ? iss_s_q   : 1'b0;

    // -------------------------------------------------------------------------
    // Writeback into response buffers
    // -------------------------------------------------------------------------
    // An illegal opcode never uses the ALU outputs. It writes zero data and
    // zero flags with err set, at the same latency as a legal operation.
    always_comb begin
        wb_illegal = (iss_cmd_q == CMD_ILLEGAL);
        wb0        = iss_valid_q & ~iss_tag_q;
        wb1        = iss_valid_q &  iss_tag_q;
        wb_data    = wb_illegal ? 32'd0 : alu_out;
        wb_eg      = wb_illegal ? 1'b0  : alu_eg;
        wb_ne      = wb_illegal ? 1'b0  : alu_ne;
        wb_err     = wb_illegal;
    end

    // Buffer contents change only on a writeback. Eligibility ensures a
    // writeback lands only in an empty or draining buffer, so a stalled
    // response is never overwritten.
    always_comb begin
        rsp0_valid_d = wb0 | (rsp0_valid_q & ~rsp0_drain);
        rsp0_data_d  = rsp0_data_q;
        rsp0_eg_d    = rsp0_eg_q;
        rsp0_ne_d    = rsp0_ne_q;
        rsp0_err_d   = rsp0_err_q;
        if (wb0) begin
            rsp0_data_d = wb_data;
            rsp0_eg_d   = wb_eg;
            rsp0_ne_d   = wb_ne;
            rsp0_err_d  = wb_err;
        end
    end

    always_comb begin
        rsp1_valid_d = wb1 | (rsp1_valid_q & ~rsp1_drain);
        rsp1_data_d  = rsp1_data_q;
        rsp1_eg_d    = rsp1_eg_q;
        rsp1_ne_d    = rsp1_ne_q;
        rsp1_err_d   = rsp1_err_q;
        if (wb1) begin
            rsp1_data_d = wb_data;
            rsp1_eg_d   = wb_eg;
            rsp1_ne_d   = wb_ne;
            rsp1_err_d  = wb_err;
        end
    end

    always_comb begin
        op_count_d = op_count_q;
        if (iss_valid_q) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q  <= 1'b0;
            iss_tag_q    <= 1'b0;
            iss_a_q      <= 32'd0;
            iss_b_q      <= 32'd0;
            iss_cmd_q    <= 3'd0;
            iss_s_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= 32'd0;
            rsp0_eg_q    <= 1'b0;
            rsp0_ne_q    <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= 32'd0;
            rsp1_eg_q    <= 1'b0;
            rsp1_ne_q    <= 1'b0;
            rsp1_err_q   <= 1'b0;
            prio_q       <= PRIO_RESET;
            op_count_q   <= 16'd0;
        end else begin
            iss_valid_q  <= iss_valid_d;
            iss_tag_q    <= iss_tag_d;
            iss_a_q      <= iss_a_d;
            iss_b_q      <= iss_b_d;
            iss_cmd_q    <= iss_cmd_d;
            iss_s_q      <= iss_s_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp0_eg_q    <= rsp0_eg_d;
            rsp0_ne_q    <= rsp0_ne_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp1_eg_q    <= rsp1_eg_d;
            rsp1_ne_q    <= rsp1_ne_d;
            rsp1_err_q   <= rsp1_err_d;
            prio_q       <= prio_d;
            op_count_q   <= op_count_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp0_eg    = rsp0_eg_q;
    assign rsp0_ne    = rsp0_ne_q;
    assign rsp0_err   = rsp0_err_q;

    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp1_eg    = rsp1_eg_q;
    assign rsp1_ne    = rsp1_ne_q;
    assign rsp1_err   = rsp1_err_q;

    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A small combinational ALU model sits on the
// alu_* side of the DUT. eg means a == b and ne means a != b. Opcode 7
// returns a junk value, so a result that comes from the ALU on an illegal
// opcode shows up as a wrong value. Inputs change and outputs are sampled
// 1 ns or more after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_s;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_cmd;
    logic        req1_valid, req1_ready, req1_s;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_cmd;
    logic        rsp0_valid, rsp0_ready, rsp0_eg, rsp0_ne, rsp0_err;
    logic [31:0] rsp0_data;
    logic        rsp1_valid, rsp1_ready, rsp1_eg, rsp1_ne, rsp1_err;
    logic [31:0] rsp1_data;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_cmd;
    logic        alu_s, alu_eg, alu_ne;
    logic [15:0] op_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_ops;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_INIT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_cmd(req0_cmd), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_cmd(req1_cmd), .req1_s(req1_s),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp0_eg(rsp0_eg), .rsp0_ne(rsp0_ne), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .rsp1_eg(rsp1_eg), .rsp1_ne(rsp1_ne), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_s(alu_s),
        .alu_out(alu_out), .alu_eg(alu_eg), .alu_ne(alu_ne),
        .op_count(op_count)
    );

    // Shared ALU model
    always_comb begin
        alu_out = 32'hDEADBEEF;
        case (alu_cmd)
            3'd0: alu_out = alu_a + alu_b;
            3'd1: alu_out = alu_a - alu_b;
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = ~(alu_a | alu_b);
            3'd6: alu_out = alu_s ? {31'd0, $signed(alu_a) < $signed(alu_b)}
                                  : {31'd0, alu_a < alu_b};
            default: alu_out = 32'hDEADBEEF;
        endcase
        alu_eg = (alu_a == alu_b);
        alu_ne = (alu_a != alu_b);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            $display("FAIL reset_ready: got %b, expected 00", {req0_ready, req1_ready}); n_fail++;
        end
        n_tests++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            $display("FAIL reset_rsp_valid: got %b, expected 00", {rsp0_valid, rsp1_valid}); n_fail++;
        end
        n_tests++;
        if ({alu_a, alu_b, alu_cmd, alu_s} !== 68'd0) begin
            $display("FAIL reset_alu: got a=%0h b=%0h cmd=%0d, expected zero", alu_a, alu_b, alu_cmd); n_fail++;
        end
        n_tests++;
        if (op_count !== 16'd0) begin
            $display("FAIL reset_op_count: got %0d, expected 0", op_count); n_fail++;
        end
        n_tests++;
        tick; tick;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
            $display("FAIL reset_held: got %b, expected 0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}); n_fail++;
        end
        n_tests++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        exp_ops = 16'd0;
    endtask

    // Runs right after reset release, so requester 0 holds priority.
    task automatic test_contention;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_cmd = 3'd1; req0_s = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd6;  req1_b = 32'd3; req1_cmd = 3'd2; req1_s = 1'b0;
        #1;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL contention_first: got %b, expected 10", {req0_ready, req1_ready}); n_fail++;
        end
        n_tests++;
        tick;
        req0_valid = 1'b0;
        #1;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            $display("FAIL contention_second: got %b, expected 01", {req0_ready, req1_ready}); n_fail++;
        end
        n_tests++;
        if (alu_cmd !== 3'd1 || alu_a !== 32'd10) begin
            $display("FAIL contention_alu0: got cmd=%0d a=%0d, expected cmd=1 a=10", alu_cmd, alu_a); n_fail++;
        end
        n_tests++;
        tick;
        req1_valid = 1'b0;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd7 || rsp1_valid !== 1'b0) begin
            $display("FAIL contention_rsp0: got v0=%b d0=%0d v1=%b, expected 1 7 0", rsp0_valid, rsp0_data, rsp1_valid); n_fail++;
        end
        n_tests++;
        tick;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b1 || rsp1_data !== 32'd2) begin
            $display("FAIL contention_rsp1: got v0=%b v1=%b d1=%0d, expected 0 1 2", rsp0_valid, rsp1_valid, rsp1_data); n_fail++;
        end
        n_tests++;
        tick;
        exp_ops = exp_ops + 16'd2;
        if (rsp1_valid !== 1'b0 || op_count !== exp_ops) begin
            $display("FAIL contention_done: got v1=%b ops=%0d, expected 0 %0d", rsp1_valid, op_count, exp_ops); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_single;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_cmd = 3'd0; req0_s = 1'b0;
        #1;
        if (req0_ready !== 1'b1) begin
            $display("FAIL single_ready: got %b, expected 1", req0_ready); n_fail++;
        end
        n_tests++;
        tick;
        req0_valid = 1'b0;
        #1;
        if (alu_cmd !== 3'd0 || alu_a !== 32'd5 || alu_b !== 32'd7 || rsp0_valid !== 1'b0) begin
            $display("FAIL single_issue: got cmd=%0d a=%0d b=%0d v=%b, expected 0 5 7 0", alu_cmd, alu_a, alu_b, rsp0_valid); n_fail++;
        end
        n_tests++;
        tick;
        exp_ops = exp_ops + 16'd1;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd12 || rsp0_eg !== 1'b0 || rsp0_ne !== 1'b1 || rsp0_err !== 1'b0) begin
            $display("FAIL single_rsp: got v=%b d=%0d eg=%b ne=%b err=%b, expected 1 12 0 1 0",
                     rsp0_valid, rsp0_data, rsp0_eg, rsp0_ne, rsp0_err); n_fail++;
        end
        n_tests++;
        if (op_count !== exp_ops || alu_a !== 32'd0) begin
            $display("FAIL single_count: got ops=%0d alu_a=%0d, expected %0d 0", op_count, alu_a, exp_ops); n_fail++;
        end
        n_tests++;
        tick;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd12) begin
            $display("FAIL single_hold: got v=%b d=%0d, expected 1 12", rsp0_valid, rsp0_data); n_fail++;
        end
        n_tests++;
        rsp0_ready = 1'b1;
        tick;
        if (rsp0_valid !== 1'b0) begin
            $display("FAIL single_drain: got %b, expected 0", rsp0_valid); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_backpressure;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h0000F0F0; req0_b = 32'h00000FF0; req0_cmd = 3'd4;
        #1;
        if (req0_ready !== 1'b1) begin
            $display("FAIL bp_first_ready: got %b, expected 1", req0_ready); n_fail++;
        end
        n_tests++;
        tick;
        req0_a = 32'd1; req0_b = 32'd1; req0_cmd = 3'd0;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_cmd = 3'd3; req1_s = 1'b0;
        #1;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            $display("FAIL bp_req1_served: got %b, expected 01", {req0_ready, req1_ready}); n_fail++;
        end
        n_tests++;
        tick;
        req1_valid = 1'b0;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h0000FF00 || alu_cmd !== 3'd3) begin
            $display("FAIL bp_rsp0: got v=%b d=%0h cmd=%0d, expected 1 ff00 3", rsp0_valid, rsp0_data, alu_cmd); n_fail++;
        end
        n_tests++;
        tick;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd3) begin
            $display("FAIL bp_rsp1: got v=%b d=%0d, expected 1 3", rsp1_valid, rsp1_data); n_fail++;
        end
        n_tests++;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (req0_ready !== 1'b0 || rsp0_valid !== 1'b1 || rsp0_data !== 32'h0000FF00) begin
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%0h, expected 0 1 ff00", i, req0_ready, rsp0_valid, rsp0_data); n_fail++;
            end
            n_tests++;
        end
        rsp0_ready = 1'b1;
        #1;
        if (req0_ready !== 1'b1) begin
            $display("FAIL bp_release_ready: got %b, expected 1", req0_ready); n_fail++;
        end
        n_tests++;
        tick;
        req0_valid = 1'b0;
        if (rsp0_valid !== 1'b0) begin
            $display("FAIL bp_drained: got %b, expected 0", rsp0_valid); n_fail++;
        end
        n_tests++;
        tick;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd2 || rsp0_eg !== 1'b1 || rsp0_ne !== 1'b0) begin
            $display("FAIL bp_second_rsp: got v=%b d=%0d eg=%b ne=%b, expected 1 2 1 0", rsp0_valid, rsp0_data, rsp0_eg, rsp0_ne); n_fail++;
        end
        n_tests++;
        tick;
        exp_ops = exp_ops + 16'd3;
        if (op_count !== exp_ops) begin
            $display("FAIL bp_count: got %0d, expected %0d", op_count, exp_ops); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_illegal;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_cmd = 3'd7; req1_s = 1'b0;
        #1;
        if (req1_ready !== 1'b1) begin
            $display("FAIL illegal_ready: got %b, expected 1", req1_ready); n_fail++;
        end
        n_tests++;
        tick;
        req1_valid = 1'b0;
        tick;
        exp_ops = exp_ops + 16'd1;
        if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b1 || rsp1_data !== 32'd0 || rsp1_eg !== 1'b0 || rsp1_ne !== 1'b0) begin
            $display("FAIL illegal_rsp: got v=%b err=%b d=%0h eg=%b ne=%b, expected 1 1 0 0 0",
                     rsp1_valid, rsp1_err, rsp1_data, rsp1_eg, rsp1_ne); n_fail++;
        end
        n_tests++;
        if (op_count !== exp_ops) begin
            $display("FAIL illegal_count: got %0d, expected %0d", op_count, exp_ops); n_fail++;
        end
        n_tests++;
        tick;
    endtask

    task automatic test_signed_slt;
        req0_valid = 1'b1; req0_a = 32'hFFFFFFFF; req0_b = 32'd1; req0_cmd = 3'd6; req0_s = 1'b1;
        tick;
        req0_valid = 1'b0;
        if (alu_s !== 1'b1 || alu_a !== 32'hFFFFFFFF || alu_cmd !== 3'd6) begin
            $display("FAIL slt_alu: got s=%b a=%0h cmd=%0d, expected 1 ffffffff 6", alu_s, alu_a, alu_cmd); n_fail++;
        end
        n_tests++;
        tick;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd1 || rsp0_err !== 1'b0) begin
            $display("FAIL slt_signed: got v=%b d=%0d err=%b, expected 1 1 0", rsp0_valid, rsp0_data, rsp0_err); n_fail++;
        end
        n_tests++;
        req0_valid = 1'b1; req0_s = 1'b0;
        tick;
        req0_valid = 1'b0;
        if (alu_s !== 1'b0) begin
            $display("FAIL sltu_alu: got s=%b, expected 0", alu_s); n_fail++;
        end
        n_tests++;
        tick;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd0) begin
            $display("FAIL sltu_rsp: got v=%b d=%0d, expected 1 0", rsp0_valid, rsp0_data); n_fail++;
        end
        n_tests++;
        tick;
        exp_ops = exp_ops + 16'd2;
    endtask

    task automatic test_reset_midflight;
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_cmd = 3'd0;
        tick;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd1; req0_cmd = 3'd0; req0_s = 1'b0;
        tick;
        req0_valid = 1'b0;
        if (alu_a !== 32'd9 || rsp1_valid !== 1'b1 || op_count !== exp_ops + 16'd1) begin
            $display("FAIL mid_precond: got alu_a=%0d v1=%b ops=%0d, expected 9 1 %0d", alu_a, rsp1_valid, op_count, exp_ops + 16'd1); n_fail++;
        end
        n_tests++;
        rst_n = 1'b0;
        #1;
        if ({rsp0_valid, rsp1_valid} !== 2'b00 || alu_a !== 32'd0 || rsp1_data !== 32'd0) begin
            $display("FAIL mid_reset_clear: got v=%b%b alu_a=%0d d1=%0d, expected 00 0 0", rsp0_valid, rsp1_valid, alu_a, rsp1_data); n_fail++;
        end
        n_tests++;
        if (op_count !== 16'd0) begin
            $display("FAIL mid_reset_count: got %0d, expected 0", op_count); n_fail++;
        end
        n_tests++;
        tick; tick;
        rst_n = 1'b1;
        rsp1_ready = 1'b1;
        exp_ops = 16'd0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if ({rsp0_valid, rsp1_valid} !== 2'b00 || op_count !== 16'd0) begin
                $display("FAIL mid_after_release[%0d]: got v=%b%b ops=%0d, expected 00 0", i, rsp0_valid, rsp1_valid, op_count); n_fail++;
            end
            n_tests++;
        end
    endtask

    // Runs after a reset, so requester 0 wins first. Operand a changes every
    // cycle, so each result shows which operands were captured.
    task automatic test_back_to_back;
        logic        exp0;
        logic        tag;
        logic        got_v;
        logic [31:0] got_d;
        logic [31:0] exp_d;
        req0_valid = 1'b1; req0_b = 32'd5; req0_cmd = 3'd0; req0_s = 1'b0;
        req1_valid = 1'b1; req1_b = 32'd5; req1_cmd = 3'd0; req1_s = 1'b0;
        for (int k = 0; k < 6; k++) begin
            req0_a = 32'(k * 16);
            req1_a = 32'(k * 16 + 1);
            #1;
            exp0 = ((k % 2) == 0);
            if (req0_ready !== exp0 || req1_ready !== ~exp0) begin
                $display("FAIL b2b_grant[%0d]: got %b%b, expected %b%b", k, req0_ready, req1_ready, exp0, ~exp0); n_fail++;
            end
            n_tests++;
            tick;
            if (k > 0) begin
                tag   = ((k - 1) % 2) == 1;
                got_v = tag ? rsp1_valid : rsp0_valid;
                got_d = tag ? rsp1_data  : rsp0_data;
                exp_d = 32'((k - 1) * 16 + 5) + {31'd0, tag};
                if (got_v !== 1'b1 || got_d !== exp_d) begin
                    $display("FAIL b2b_rsp[%0d]: got v=%b d=%0d, expected 1 %0d", k - 1, got_v, got_d, exp_d); n_fail++;
                end
                n_tests++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd86) begin
            $display("FAIL b2b_rsp[5]: got v=%b d=%0d, expected 1 86", rsp1_valid, rsp1_data); n_fail++;
        end
        n_tests++;
        tick;
        exp_ops = exp_ops + 16'd6;
        if (op_count !== exp_ops) begin
            $display("FAIL b2b_count: got %0d, expected %0d", op_count, exp_ops); n_fail++;
        end
        n_tests++;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_cmd = 3'd0; req0_s = 1'b0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_cmd = 3'd0; req1_s = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        exp_ops = 16'd0;
        @(posedge clk);
        #1;
        test_reset;
        test_contention;
        test_single;
        test_backpressure;
        test_illegal;
        test_signed_slt;
        test_reset_midflight;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 0; selects which requester holds round-robin priority after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports reqN_valid  input  1  and reqN_ready  output  1  (N=0,1): request handshake for requester N.
REQ-005 SHALL have ports reqN_a, reqN_b  input  32  operands; reqN_cmd  input  3  opcode; reqN_s  input  1  signed-mode flag.
REQ-006 SHALL have ports rspN_valid  output  1  and rspN_ready  input  1: response handshake for requester N.
REQ-007 SHALL have ports rspN_data  output  32  result; rspN_eg, rspN_ne  output  1  compare flags; rspN_err  output  1  illegal-opcode flag.
REQ-008 SHALL have ports alu_a, alu_b  output  32; alu_cmd  output  3; alu_s  output  1: operands/controls to the shared ALU.
REQ-009 SHALL have ports alu_out  input  32; alu_eg, alu_ne  input  1: combinational results from the shared ALU.
REQ-010 SHALL have port op_count  output  16  count of operations completed into response buffers.

Function
REQ-011 SHALL use opcode encoding add=0, sub=1, and=2, or=3, xor=4, nor=5, slt=6; opcode 7 is illegal.
REQ-012 SHALL transfer a request when reqN_valid & reqN_ready are high at a rising edge; likewise for responses.
REQ-013 SHALL contain one issue register (valid, tag, a, b, cmd, s) and one response buffer per requester (valid, data, eg, ne, err).
REQ-014 SHALL make requester N eligible only when rspN buffer is empty or drained this cycle (rspN_valid & rspN_ready), and the issue register does not hold a tag-N operation; at most one operation is outstanding per requester.
REQ-015 SHALL grant at most one requester per cycle; reqN_ready SHALL be high only for the granted requester, and SHALL be independent of reqN_valid of the other requester's outcome only through arbitration.
REQ-016 SHALL arbitrate round-robin: if both valid and eligible, grant the priority holder; after any grant, priority passes to the other requester; an ungranted cycle leaves priority unchanged.
REQ-017 SHALL capture the granted request into the issue register at the accepting edge (cycle T); the issue register SHALL clear at edge T+1 unless refilled by a new grant.
REQ-018 SHALL drive alu_a/alu_b/alu_cmd/alu_s from the issue register; when it is empty SHALL drive all zero.
REQ-019 SHALL write alu_out, alu_eg, alu_ne into the tagged response buffer at edge T+1, so rspN_valid rises at T+1 (two-edge latency from acceptance); err=0.
REQ-020 SHALL, for opcode 7, write data=0, eg=0, ne=0, err=1 into the response buffer with the same latency, ignoring ALU outputs.
REQ-021 SHALL hold response buffer contents stable while rspN_valid & !rspN_ready; SHALL clear rspN_valid on drain unless refilled the same edge.
REQ-022 SHALL accept back-to-back grants alternating between requesters, one per cycle, with no bubbles.
REQ-023 SHALL increment op_count by 1 on each response-buffer write (including err), wrapping 0xFFFF -> 0x0000.
REQ-024 SHALL never let a request's operands change after acceptance affect its result.

Reset
REQ-025 SHALL on rst_n low immediately clear issue-register valid, both rsp valids, all rsp data/flags, op_count, and drive reqN_ready=0, alu_* = 0.
REQ-026 SHALL set round-robin priority to requester RR_INIT on reset.
REQ-027 SHALL discard any in-flight issue or buffered response when reset asserts mid-operation; no response emerges after reset release.
REQ-028 SHALL allow first grant at the first rising edge after rst_n deasserts.

Verification
REQ-029 Single op: req0 add a=5 b=7 accepted at edge T -> alu_cmd=0 during T..T+1, rsp0_valid=1 after T+1, rsp0_data=12, eg=0, ne=1, op_count=1.
REQ-030 Contention: both valid, RR_INIT=0 -> req0 granted first, req1 next cycle; rsp0 and rsp1 each valid one cycle apart.
REQ-031 Backpressure: req0 issued, rsp0_ready=0 for 5 cycles -> rsp0 data held, req0_ready stays 0 for new req0, req1 still served.
REQ-032 Illegal opcode: req1 cmd=7 -> rsp1_err=1, rsp1_data=0, op_count increments.
REQ-033 Signed slt: req0 cmd=6 s=1 a=0xFFFFFFFF b=1 -> alu_s=1 presented; rsp0_data equals alu_out returned by ALU model.
REQ-034 Reset mid-flight: assert rst_n low while issue register valid -> all valids 0 immediately; no response after release; op_count=0.
